// File: rtl/zet_prefetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
// Contents:
//   pfq_state_e  - fetch FSM states (idle, bus request, drain a stale bus cycle)
//   PFQ_RESET_*  - default code segment / instruction pointer loaded at reset
//   pfq_linear   - real-mode linear address (cs<<4)+ip, 20-bit wrap
//   pfq_wrap     - pointer advance modulo an arbitrary (non power-of-two) depth
package zet_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } pfq_state_e;

    localparam logic [15:0] PFQ_RESET_CS = 16'hF000;
    localparam logic [15:0] PFQ_RESET_IP = 16'hFFF0;

    function automatic logic [19:0] pfq_linear(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'h0} + {4'h0, ip};
    endfunction

    // Advance is at most 2 and depth is at least 4, so one subtraction suffices.
    function automatic int unsigned pfq_wrap(input int unsigned ptr, input int unsigned n,
                                             input int unsigned depth);
        return (ptr + n >= depth) ? ptr + n - depth : ptr + n;
    endfunction

endpackage

// File: rtl/zet_pfq_store.sv
// Byte-wide circular storage for the prefetch queue.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (write pointer only)
//   clear             restart the write pointer at slot 0
//   we, wr_count      write wr_count (1..BUS_BYTES) bytes from wr_data, byte 0 first
//   wr_data           bytes to store, byte k lands at wr_ptr+k (mod DEPTH)
//   rd_ptr            head slot supplied by the owner of the read side
//   rd_byte0/1        combinational reads of slots rd_ptr and rd_ptr+1 (mod DEPTH)
module zet_pfq_store
    import zet_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 6,
    parameter int unsigned BUS_BYTES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     we,
    input  logic [1:0]               wr_count,
    input  logic [8*BUS_BYTES-1:0]   wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [7:0]               rd_byte0,
    output logic [7:0]               rd_byte1
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
        end else if (we) begin
            wr_ptr_q <= PW'(pfq_wrap(32'(wr_ptr_q), 32'(wr_count), DEPTH));
        end
    end

    // Storage itself needs no reset: q_count gates which slots are meaningful.
    always_ff @(posedge clk) begin
        if (we && !clear) begin
            for (int unsigned k = 0; k < BUS_BYTES; k++) begin
                if (k < 32'(wr_count)) begin
                    mem[PW'(pfq_wrap(32'(wr_ptr_q), k, DEPTH))] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    assign rd_byte0 = mem[rd_ptr];
    assign rd_byte1 = mem[PW'(pfq_wrap(32'(rd_ptr), 32'd1, DEPTH))];

endmodule

// File: rtl/zet_prefetch_queue.sv
// Instruction prefetch queue: fetches code bytes ahead of execution from CS:IP into a
// byte-wide circular queue and presents the two head bytes to decode.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   flush, flush_cs, flush_ip  discard queue and restart fetching at flush_cs:flush_ip
//   mem_adr, mem_stb           registered bus request (address held until mem_ack)
//   mem_ack, mem_dat           bus completion and read data (byte k = mem_adr+k)
//   q_byte0, q_byte1           head byte and the byte after it
//   q_count, q_ip              bytes held, IP of q_byte0
//   pop                        bytes consumed this cycle (0..2)
//   pop_err                    one-cycle pulse when pop exceeded q_count (pop ignored)
module zet_prefetch_queue
    import zet_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 6,
    parameter int unsigned BUS_BYTES = 2,
    parameter logic [15:0] RESET_CS  = PFQ_RESET_CS,
    parameter logic [15:0] RESET_IP  = PFQ_RESET_IP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [15:0]                flush_cs,
    input  logic [15:0]                flush_ip,
    output logic [19:0]                mem_adr,
    output logic                       mem_stb,
    input  logic                       mem_ack,
    input  logic [8*BUS_BYTES-1:0]     mem_dat,
    output logic [7:0]                 q_byte0,
    output logic [7:0]                 q_byte1,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic [15:0]                q_ip,
    input  logic [1:0]                 pop,
    output logic                       pop_err
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    pfq_state_e    state_q;
    logic [15:0]   fetch_cs_q;
    logic [15:0]   fetch_ip_q;
    logic [15:0]   q_ip_q;
    logic [CW-1:0] q_count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [19:0]   mem_adr_q;
    logic          mem_stb_q;
    logic          pop_err_q;

    logic                   odd_start;
    logic                   enq;
    logic                   pop_ok;
    logic                   has_room;
    logic [1:0]             n_in;
    logic [1:0]             pop_amt;
    logic [15:0]            fetch_ip_aligned;
    logic [8*BUS_BYTES-1:0] wr_data;
    logic [CW-1:0]          q_count_d;

    always_comb begin
        // A word bus cannot start on an odd byte: fetch the aligned word, keep its high byte.
        odd_start        = (BUS_BYTES == 2) && fetch_ip_q[0];
        n_in             = odd_start ? 2'd1 : 2'(BUS_BYTES);
        fetch_ip_aligned = odd_start ? {fetch_ip_q[15:1], 1'b0} : fetch_ip_q;
        wr_data          = odd_start ? (mem_dat >> 8) : mem_dat;
        enq              = (state_q == StFetch) && mem_ack && !flush;
        pop_ok           = CW'(pop) <= q_count_q;
        pop_amt          = pop_ok ? pop : 2'd0;
        has_room         = q_count_q <= CW'(DEPTH - BUS_BYTES);
        q_count_d        = q_count_q + (enq ? CW'(n_in) : '0) - CW'(pop_amt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_cs_q <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            q_ip_q     <= RESET_IP;
            q_count_q  <= '0;
            rd_ptr_q   <= '0;
            mem_adr_q  <= '0;
            mem_stb_q  <= 1'b0;
            pop_err_q  <= 1'b0;
        end else begin
            // A pop swallowed by a flush is not an error.
            pop_err_q <= !flush && !pop_ok;

            if (flush) begin
                q_count_q  <= '0;
                rd_ptr_q   <= '0;
                fetch_cs_q <= flush_cs;
                fetch_ip_q <= flush_ip;
                q_ip_q     <= flush_ip;
            end else begin
                q_count_q <= q_count_d;
                rd_ptr_q  <= PW'(pfq_wrap(32'(rd_ptr_q), 32'(pop_amt), DEPTH));
                q_ip_q    <= q_ip_q + 16'(pop_amt);
                if (enq) begin
                    fetch_ip_q <= fetch_ip_q + 16'(n_in);
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (!flush && has_room) begin
                        state_q   <= StFetch;
                        mem_stb_q <= 1'b1;
                        mem_adr_q <= pfq_linear(fetch_cs_q, fetch_ip_aligned);
                    end
                end
                StFetch: begin
                    if (mem_ack) begin
                        state_q   <= StIdle;
                        mem_stb_q <= 1'b0;
                    end else if (flush) begin
                        // Bus cycle still owed an ack; its data belongs to the old stream.
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (mem_ack) begin
                        state_q   <= StIdle;
                        mem_stb_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_stb_q <= 1'b0;
                end
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(enq && (q_count_q == CW'(DEPTH))));

    zet_pfq_store #(
        .DEPTH     (DEPTH),
        .BUS_BYTES (BUS_BYTES)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .we       (enq),
        .wr_count (n_in),
        .wr_data  (wr_data),
        .rd_ptr   (rd_ptr_q),
        .rd_byte0 (q_byte0),
        .rd_byte1 (q_byte1)
    );

    assign mem_adr = mem_adr_q;
    assign mem_stb = mem_stb_q;
    assign q_count = q_count_q;
    assign q_ip    = q_ip_q;
    assign pop_err = pop_err_q;

endmodule

// File: tb/tb_zet_prefetch_queue.sv
// Directed bench for zet_prefetch_queue: instance a uses DEPTH=6 / word bus, instance b
// uses DEPTH=7 / byte bus. Memory returns the low byte of each byte address unless an
// override word is selected; acks are combinational from mem_stb under bench control.
module tb_zet_prefetch_queue;

    logic clk;
    logic rst;

    logic        a_flush, a_mem_stb, a_mem_ack, a_pop_err, a_ack_en, a_ovr_en;
    logic [15:0] a_flush_cs, a_flush_ip, a_mem_dat, a_q_ip, a_ovr;
    logic [19:0] a_mem_adr;
    logic [7:0]  a_q_byte0, a_q_byte1;
    logic [2:0]  a_q_count;
    logic [1:0]  a_pop;

    logic        b_flush, b_mem_stb, b_mem_ack, b_pop_err, b_ack_en;
    logic [15:0] b_flush_cs, b_flush_ip, b_q_ip;
    logic [7:0]  b_mem_dat;
    logic [19:0] b_mem_adr;
    logic [7:0]  b_q_byte0, b_q_byte1;
    logic [2:0]  b_q_count;
    logic [1:0]  b_pop;

    int n_err = 0;
    int n_chk = 0;

    assign a_mem_ack = a_mem_stb & a_ack_en;
    assign a_mem_dat = a_ovr_en ? a_ovr : {a_mem_adr[7:0] + 8'd1, a_mem_adr[7:0]};
    assign b_mem_ack = b_mem_stb & b_ack_en;
    assign b_mem_dat = b_mem_adr[7:0];

    zet_prefetch_queue #(
        .DEPTH     (6),
        .BUS_BYTES (2)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .flush    (a_flush),
        .flush_cs (a_flush_cs),
        .flush_ip (a_flush_ip),
        .mem_adr  (a_mem_adr),
        .mem_stb  (a_mem_stb),
        .mem_ack  (a_mem_ack),
        .mem_dat  (a_mem_dat),
        .q_byte0  (a_q_byte0),
        .q_byte1  (a_q_byte1),
        .q_count  (a_q_count),
        .q_ip     (a_q_ip),
        .pop      (a_pop),
        .pop_err  (a_pop_err)
    );

    zet_prefetch_queue #(
        .DEPTH     (7),
        .BUS_BYTES (1)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .flush    (b_flush),
        .flush_cs (b_flush_cs),
        .flush_ip (b_flush_ip),
        .mem_adr  (b_mem_adr),
        .mem_stb  (b_mem_stb),
        .mem_ack  (b_mem_ack),
        .mem_dat  (b_mem_dat),
        .q_byte0  (b_q_byte0),
        .q_byte1  (b_q_byte1),
        .q_count  (b_q_count),
        .q_ip     (b_q_ip),
        .pop      (b_pop),
        .pop_err  (b_pop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_a_count(input logic [2:0] n);
        int k = 0;
        while (a_q_count !== n && k < 30) begin
            tick();
            k++;
        end
        check_eq("a_wait_count", 32'(a_q_count), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        a_flush = 0; a_flush_cs = '0; a_flush_ip = '0; a_pop = 0;
        a_ack_en = 1; a_ovr_en = 0; a_ovr = '0;
        b_flush = 0; b_flush_cs = '0; b_flush_ip = '0; b_pop = 0; b_ack_en = 1;
        tick(); tick();

        // Reset state
        check_eq("rst_a_count", 32'(a_q_count), 0);
        check_eq("rst_a_stb", 32'(a_mem_stb), 0);
        check_eq("rst_a_ip", 32'(a_q_ip), 32'hFFF0);
        check_eq("rst_a_perr", 32'(a_pop_err), 0);
        check_eq("rst_b_count", 32'(b_q_count), 0);
        check_eq("rst_b_ip", 32'(b_q_ip), 32'hFFF0);

        // Fill from the reset vector with single-cycle acks
        rst = 1'b1;
        tick();
        check_eq("fill_a_stb", 32'(a_mem_stb), 1);
        check_eq("fill_a_adr", 32'(a_mem_adr), 32'hFFFF0);
        check_eq("fill_b_adr", 32'(b_mem_adr), 32'hFFFF0);
        tick();
        check_eq("fill_a_cnt2", 32'(a_q_count), 2);
        check_eq("fill_a_b0", 32'(a_q_byte0), 32'hF0);
        check_eq("fill_a_b1", 32'(a_q_byte1), 32'hF1);
        repeat (20) tick();
        check_eq("full_a_cnt", 32'(a_q_count), 6);
        check_eq("full_a_stb", 32'(a_mem_stb), 0);
        check_eq("full_a_ip", 32'(a_q_ip), 32'hFFF0);
        check_eq("full_b_cnt", 32'(b_q_count), 7);
        check_eq("full_b_stb", 32'(b_mem_stb), 0);
        check_eq("full_b_b0", 32'(b_q_byte0), 32'hF0);
        check_eq("full_b_b1", 32'(b_q_byte1), 32'hF1);

        // One free byte is not enough for a word fetch
        a_pop = 1;
        tick();
        a_pop = 0;
        check_eq("free1_a_cnt", 32'(a_q_count), 5);
        check_eq("free1_a_ip", 32'(a_q_ip), 32'hFFF1);
        check_eq("free1_a_b0", 32'(a_q_byte0), 32'hF1);
        repeat (3) tick();
        check_eq("free1_a_stb", 32'(a_mem_stb), 0);
        check_eq("free1_a_cnt2", 32'(a_q_count), 5);

        // Odd start address
        a_ovr = 16'hBBAA; a_ovr_en = 1;
        a_flush = 1; a_flush_cs = 16'h1000; a_flush_ip = 16'h0003;
        tick();
        a_flush = 0;
        check_eq("odd_cnt0", 32'(a_q_count), 0);
        check_eq("odd_ip0", 32'(a_q_ip), 32'h0003);
        tick();
        check_eq("odd_stb", 32'(a_mem_stb), 1);
        check_eq("odd_adr", 32'(a_mem_adr), 32'h10002);
        tick();
        a_ovr_en = 0;
        check_eq("odd_cnt1", 32'(a_q_count), 1);
        check_eq("odd_b0", 32'(a_q_byte0), 32'hBB);
        check_eq("odd_ip", 32'(a_q_ip), 32'h0003);
        tick();
        check_eq("odd_adr2", 32'(a_mem_adr), 32'h10004);
        tick();
        check_eq("odd_cnt3", 32'(a_q_count), 3);
        check_eq("odd_b1", 32'(a_q_byte1), 32'h04);

        // Pop coincident with enqueue, then pop underflow
        a_flush = 1; a_flush_cs = 16'h1000; a_flush_ip = 16'h0010;
        tick();
        a_flush = 0;
        wait_a_count(3'd4);
        a_ack_en = 0;
        tick();
        check_eq("co_stb", 32'(a_mem_stb), 1);
        check_eq("co_adr", 32'(a_mem_adr), 32'h10014);
        a_pop = 2; a_ack_en = 1;
        tick();
        a_pop = 0; a_ack_en = 0;
        check_eq("co_cnt", 32'(a_q_count), 4);
        check_eq("co_ip", 32'(a_q_ip), 32'h0012);
        check_eq("co_b0", 32'(a_q_byte0), 32'h12);
        check_eq("co_b1", 32'(a_q_byte1), 32'h13);
        a_pop = 2;
        tick();
        check_eq("pop2_cnt", 32'(a_q_count), 2);
        check_eq("pop2_b0", 32'(a_q_byte0), 32'h14);
        check_eq("pop2_b1", 32'(a_q_byte1), 32'h15);
        a_pop = 1;
        tick();
        check_eq("pop1_cnt", 32'(a_q_count), 1);
        check_eq("pop1_ip", 32'(a_q_ip), 32'h0015);
        check_eq("pend_adr", 32'(a_mem_adr), 32'h10016);
        a_pop = 2;
        tick();
        a_pop = 0;
        check_eq("perr_flag", 32'(a_pop_err), 1);
        check_eq("perr_cnt", 32'(a_q_count), 1);
        check_eq("perr_ip", 32'(a_q_ip), 32'h0015);
        check_eq("perr_b0", 32'(a_q_byte0), 32'h15);
        tick();
        check_eq("perr_pulse", 32'(a_pop_err), 0);

        // Flush while a request is outstanding; stale ack three cycles later
        a_flush = 1; a_flush_cs = 16'h3000; a_flush_ip = 16'h0100; a_pop = 2;
        a_ovr = 16'hDEAD; a_ovr_en = 1;
        tick();
        a_flush = 0; a_pop = 0;
        check_eq("drn_perr", 32'(a_pop_err), 0);
        check_eq("drn_cnt", 32'(a_q_count), 0);
        check_eq("drn_stb", 32'(a_mem_stb), 1);
        check_eq("drn_adr", 32'(a_mem_adr), 32'h10016);
        tick(); tick();
        a_ack_en = 1;
        tick();
        a_ovr_en = 0;
        check_eq("drn_cnt2", 32'(a_q_count), 0);
        check_eq("drn_stb2", 32'(a_mem_stb), 0);
        tick();
        check_eq("drn_new_stb", 32'(a_mem_stb), 1);
        check_eq("drn_new_adr", 32'(a_mem_adr), 32'h30100);
        tick();
        check_eq("drn_new_cnt", 32'(a_q_count), 2);
        check_eq("drn_new_b0", 32'(a_q_byte0), 32'h00);
        check_eq("drn_new_b1", 32'(a_q_byte1), 32'h01);
        check_eq("drn_new_ip", 32'(a_q_ip), 32'h0100);

        // IP wrap within the segment
        a_flush = 1; a_flush_cs = 16'h2000; a_flush_ip = 16'hFFFE;
        tick();
        a_flush = 0;
        check_eq("wrap_ip0", 32'(a_q_ip), 32'hFFFE);
        tick();
        check_eq("wrap_adr1", 32'(a_mem_adr), 32'h2FFFE);
        tick();
        check_eq("wrap_b0", 32'(a_q_byte0), 32'hFE);
        check_eq("wrap_b1", 32'(a_q_byte1), 32'hFF);
        tick();
        check_eq("wrap_adr2", 32'(a_mem_adr), 32'h20000);
        tick();
        check_eq("wrap_cnt4", 32'(a_q_count), 4);
        a_pop = 2;
        tick();
        a_pop = 0;
        check_eq("wrap_ip", 32'(a_q_ip), 32'h0000);
        check_eq("wrap_cnt2", 32'(a_q_count), 2);
        check_eq("wrap_b0b", 32'(a_q_byte0), 32'h00);
        check_eq("wrap_b1b", 32'(a_q_byte1), 32'h01);

        // DEPTH=7, byte bus: both pointers cross the non-power-of-two boundary
        b_ack_en = 0; b_pop = 2;
        tick();
        check_eq("b_cnt5", 32'(b_q_count), 5);
        check_eq("b_ip2", 32'(b_q_ip), 32'hFFF2);
        check_eq("b_b0_f2", 32'(b_q_byte0), 32'hF2);
        check_eq("b_b1_f3", 32'(b_q_byte1), 32'hF3);
        tick();
        check_eq("b_cnt3", 32'(b_q_count), 3);
        check_eq("b_b0_f4", 32'(b_q_byte0), 32'hF4);
        check_eq("b_stb", 32'(b_mem_stb), 1);
        check_eq("b_adr7", 32'(b_mem_adr), 32'hFFFF7);
        b_ack_en = 1;
        tick();
        b_ack_en = 0;
        check_eq("b_co_cnt", 32'(b_q_count), 2);
        check_eq("b_co_ip", 32'(b_q_ip), 32'hFFF6);
        check_eq("b_co_b0", 32'(b_q_byte0), 32'hF6);
        check_eq("b_co_b1", 32'(b_q_byte1), 32'hF7);
        tick();
        b_pop = 0;
        check_eq("b_empty", 32'(b_q_count), 0);
        check_eq("b_ip8", 32'(b_q_ip), 32'hFFF8);
        check_eq("b_adr8", 32'(b_mem_adr), 32'hFFFF8);
        b_ack_en = 1;
        tick();
        b_ack_en = 0;
        check_eq("b_cnt1", 32'(b_q_count), 1);
        check_eq("b_b0_f8", 32'(b_q_byte0), 32'hF8);
        b_pop = 2;
        tick();
        b_pop = 0;
        check_eq("b_perr", 32'(b_pop_err), 1);
        check_eq("b_perr_cnt", 32'(b_q_count), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
